alu_nibble_sequencer: RTL and testbench
=======================================

// Module: alu_nibble_sequencer
// PURPOSE
//   Initiator side of the 4-bit ALU select/carry interface. Accepts one wide
//   arithmetic request over a valid/ready handshake and drives the 4-bit ALU core
//   (A, B, S1, S0, Cin -> D, Cout) one nibble per cycle, LSB nibble first.
//   Each nibble's Cout is chained into the next nibble's Cin.
//   The assembled result is returned on a valid/ready response channel.
//   Sits between the datapath controller and the combinational ALU core.
// PARAMETERS
//   N_NIBBLES  4  operand width in nibbles; data width W = 4*N_NIBBLES (>=1)
// PORTS
//   clk          in   1    single clock, rising edge
//   rst          in   1    synchronous, active-high reset
//   req_valid    in   1    request present
//   req_ready    out  1    block can accept a request (high only in IDLE)
//   req_a        in   W    operand A
//   req_b        in   W    operand B
//   req_sel      in   2    {S1,S0}: 00 A+B+Cin, 01 A+~B+Cin, 10 A+Cin, 11 A+~0+Cin
//   req_cin      in   1    carry into nibble 0
//   rsp_valid    out  1    response present
//   rsp_ready    in   1    consumer accepts response
//   rsp_d        out  W    result
//   rsp_cout     out  1    carry out of the top nibble
//   rsp_zero     out  1    rsp_d == 0
//   alu_a        out  4    nibble of A to the ALU core
//   alu_b        out  4    nibble of B to the ALU core
//   alu_s1       out  1    ALU select bit 1 (= latched req_sel[1])
//   alu_s0       out  1    ALU select bit 0 (= latched req_sel[0])
//   alu_cin      out  1    ALU carry in
//   alu_d        in   4    ALU result nibble (combinational, same cycle)
//   alu_cout     in   1    ALU carry out (combinational, same cycle)
// BEHAVIOUR
//   - FSM states: IDLE -> EXEC -> DONE -> IDLE.
//   - Reset: state=IDLE, nibble counter=0, carry_reg=0, result reg=0.
//     Reset also forces rsp_valid=0, rsp_cout=0, rsp_zero=1, and alu_* outputs=0.
//   - IDLE
//     - req_ready=1.
//     - On the edge where req_valid && req_ready: latch a, b, sel, cin; clear result.
//     - Set counter k=0 and go to EXEC.
//   - EXEC, cycle k (k = 0 .. N_NIBBLES-1)
//     - alu_a=a[4k+3:4k], alu_b=b[4k+3:4k], {alu_s1,alu_s0}=sel.
//     - alu_cin = (k==0) ? cin : carry_reg.
//     - At the edge: result[4k+3:4k] <= alu_d, carry_reg <= alu_cout.
//     - If k==N_NIBBLES-1, go to DONE; else k <= k+1.
//   - DONE
//     - rsp_valid=1; rsp_d, rsp_cout (=carry_reg) and rsp_zero stay stable while rsp_ready=0.
//     - On rsp_valid && rsp_ready, go to IDLE.
//   - Latency: request accepted at edge E; rsp_valid asserted from edge E+N_NIBBLES.
//     - One request in flight at most; next req_ready is the cycle after the response handshake.
//   - alu_* outputs are 0 in IDLE and DONE and are only meaningful in EXEC.
//   - Carry is never masked: the final Cout is the carry/no-borrow of the full W-bit operation.
//   - Wrap-around results are modulo 2^W. No overflow flag.
//   - req_valid while not in IDLE is ignored (req_ready=0). Request inputs are sampled only at acceptance.
//   - rst asserted in any state, including mid-EXEC: the next edge returns to IDLE.
//     - The partial result is discarded and no response is produced.
// TESTING (N_NIBBLES=4, ALU core instantiated behind the alu_* ports)
//   1. add: a=0x1234 b=0x0FCD sel=00 cin=0 -> rsp_d=0x2201 cout=0 zero=0, rsp_valid 4 cycles after accept
//   2. sub: a=0x0005 b=0x0003 sel=01 cin=1 -> rsp_d=0x0002 cout=1; same with cin=0 -> 0x0001 cout=1
//   3. inc wrap: a=0xFFFF sel=10 cin=1 -> rsp_d=0x0000 cout=1 zero=1; dec: a=0x0000 sel=11 cin=0 -> 0xFFFF cout=0
//   4. backpressure: hold rsp_ready=0 for 3 cycles -> rsp_d/cout stable, req_ready=0, new req_valid ignored
//   5. reset mid-EXEC at k=2 -> next cycle req_ready=1, rsp_valid=0, alu_*=0; next request computes correctly
//   6. back-to-back: two requests with rsp_ready=1 -> second accepted the cycle after the first response handshake

Source files
------------

// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer
// Drives an external 4-bit ALU core one nibble per cycle, LSB nibble first.
// The carry is chained between nibbles, and the wide result is returned on a
// valid/ready response channel. At most one request is in flight at a time.
module alu_nibble_sequencer #(
  parameter int N_NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [4*N_NIBBLES-1:0]   req_a,
  input  logic [4*N_NIBBLES-1:0]   req_b,
  input  logic [1:0]               req_sel,
  input  logic                     req_cin,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [4*N_NIBBLES-1:0]   rsp_d,
  output logic                     rsp_cout,
  output logic                     rsp_zero,
  output logic [3:0]               alu_a,
  output logic [3:0]               alu_b,
  output logic                     alu_s1,
  output logic                     alu_s0,
  output logic                     alu_cin,
  input  logic [3:0]               alu_d,
  input  logic                     alu_cout
);

  localparam int W  = 4 * N_NIBBLES;
  localparam int CW = (N_NIBBLES > 1) ? $clog2(N_NIBBLES) : 1;
  localparam logic [CW-1:0] K_LAST = CW'(N_NIBBLES - 1);
  localparam logic [CW-1:0] K_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   k_r;
  logic [W-1:0]    a_sh_r;
  logic [W-1:0]    b_sh_r;
  logic [W-1:0]    result_r;
  logic            carry_r;

  // Operand shifters expose the next nibble at bit 0. The result shifts in
  // from the top, so after N_NIBBLES steps nibble 0 lands at the bottom.
  logic [W-1:0]    a_next_s;
  logic [W-1:0]    b_next_s;
  logic [W+3:0]    res_cat_s;
  logic [W-1:0]    res_next_s;

  assign a_next_s   = a_sh_r >> 3'd4;
  assign b_next_s   = b_sh_r >> 3'd4;
  assign res_cat_s  = {alu_d, result_r};
  assign res_next_s = res_cat_s[W+3:4];

  // The response data and carry come straight from their holding registers.
  assign rsp_d    = result_r;
  assign rsp_cout = carry_r;

  // Sequencer FSM: accept, execute one nibble per cycle, then hold the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      k_r       <= '0;
      a_sh_r    <= '0;
      b_sh_r    <= '0;
      result_r  <= '0;
      carry_r   <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_zero  <= 1'b1;
      alu_a     <= 4'h0;
      alu_b     <= 4'h0;
      alu_s1    <= 1'b0;
      alu_s0    <= 1'b0;
      alu_cin   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid && req_ready) begin
            // Nibble 0 is presented to the ALU in the first EXEC cycle.
            a_sh_r    <= req_a;
            b_sh_r    <= req_b;
            alu_a     <= req_a[3:0];
            alu_b     <= req_b[3:0];
            alu_s1    <= req_sel[1];
            alu_s0    <= req_sel[0];
            alu_cin   <= req_cin;
            result_r  <= '0;
            rsp_zero  <= 1'b1;
            k_r       <= '0;
            req_ready <= 1'b0;
            state_r   <= EXEC;
          end else begin
            req_ready <= 1'b1;
            state_r   <= IDLE;
          end
        end
        EXEC: begin
          result_r <= res_next_s;
          carry_r  <= alu_cout;
          rsp_zero <= (res_next_s == '0);
          if (k_r == K_LAST) begin
            // The ALU is quiet outside EXEC.
            alu_a     <= 4'h0;
            alu_b     <= 4'h0;
            alu_s1    <= 1'b0;
            alu_s0    <= 1'b0;
            alu_cin   <= 1'b0;
            rsp_valid <= 1'b1;
            state_r   <= DONE;
          end else begin
            // The carry out of this nibble feeds the carry in of the next nibble.
            k_r     <= k_r + K_ONE;
            a_sh_r  <= a_next_s;
            b_sh_r  <= b_next_s;
            alu_a   <= a_next_s[3:0];
            alu_b   <= b_next_s[3:0];
            alu_cin <= alu_cout;
            state_r <= EXEC;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state_r   <= IDLE;
          end else begin
            rsp_valid <= 1'b1;
            state_r   <= DONE;
          end
        end
        default: begin
          state_r   <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          alu_a     <= 4'h0;
          alu_b     <= 4'h0;
          alu_s1    <= 1'b0;
          alu_s0    <= 1'b0;
          alu_cin   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Testbench for alu_nibble_sequencer (N_NIBBLES=4).
// A behavioural 4-bit ALU core sits behind the alu_* ports.
// Directed vectors are applied from a table, and hand-written sequences
// cover backpressure, a mid-operation reset and back-to-back requests.
module tb_alu_nibble_sequencer;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [1:0]  req_sel;
  logic        req_cin;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_d;
  logic        rsp_cout;
  logic        rsp_zero;
  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic        alu_s1;
  logic        alu_s0;
  logic        alu_cin;
  logic [3:0]  alu_d;
  logic        alu_cout;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  sel;
    logic        cin;
    logic [15:0] d;
    logic        cout;
    logic        zero;
  } vec_t;

  vec_t vecs [8];

  alu_nibble_sequencer #(.N_NIBBLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sel   (req_sel),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_d     (rsp_d),
    .rsp_cout  (rsp_cout),
    .rsp_zero  (rsp_zero),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_s1    (alu_s1),
    .alu_s0    (alu_s0),
    .alu_cin   (alu_cin),
    .alu_d     (alu_d),
    .alu_cout  (alu_cout)
  );

  // Behavioural 4-bit ALU core: D = A + Bop + Cin, where Bop is chosen by {S1,S0}.
  logic [3:0] bop;
  logic [4:0] sum;
  always_comb begin
    case ({alu_s1, alu_s0})
      2'b00:   bop = alu_b;
      2'b01:   bop = ~alu_b;
      2'b10:   bop = 4'h0;
      default: bop = 4'hF;
    endcase
    sum = {1'b0, alu_a} + {1'b0, bop} + {4'h0, alu_cin};
  end
  assign alu_d    = sum[3:0];
  assign alu_cout = sum[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake monitor: records the cycle numbers of accepts and response handshakes.
  int          cyc = 0;
  int          acc_cnt = 0;
  int          acc_cyc = 0;
  int          hs_cnt = 0;
  int          hs_cyc = 0;
  logic [15:0] hs_d = 16'h0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && req_valid && req_ready) begin
      acc_cnt <= acc_cnt + 1;
      acc_cyc <= cyc;
    end
    if (!rst && rsp_valid && rsp_ready) begin
      hs_cnt <= hs_cnt + 1;
      hs_cyc <= cyc;
      hs_d   <= rsp_d;
    end
  end

  // Watchdog so that the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits for req_ready and presents one request. Returns at the negedge after
  // the accepting edge, which is EXEC nibble 0.
  task automatic start_req(input vec_t v);
    int guard;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_req", 32'(req_ready), 32'h1);
    req_a     = v.a;
    req_b     = v.b;
    req_sel   = v.sel;
    req_cin   = v.cin;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Counts the edges from acceptance until rsp_valid is seen (0 on timeout).
  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    start_req(v);
    check($sformatf("v%0d_alu_a_k0", idx), 32'(alu_a), 32'(v.a[3:0]));
    check($sformatf("v%0d_alu_b_k0", idx), 32'(alu_b), 32'(v.b[3:0]));
    check($sformatf("v%0d_alu_sel", idx), 32'({alu_s1, alu_s0}), 32'(v.sel));
    check($sformatf("v%0d_alu_cin_k0", idx), 32'(alu_cin), 32'(v.cin));
    check($sformatf("v%0d_ready_busy", idx), 32'(req_ready), 32'h0);
    wait_rsp(lat);
    check($sformatf("v%0d_latency", idx), 32'(lat), 32'd4);
    check($sformatf("v%0d_rsp_d", idx), 32'(rsp_d), 32'(v.d));
    check($sformatf("v%0d_rsp_cout", idx), 32'(rsp_cout), 32'(v.cout));
    check($sformatf("v%0d_rsp_zero", idx), 32'(rsp_zero), 32'(v.zero));
    check($sformatf("v%0d_alu_idle", idx), 32'({alu_a, alu_b, alu_s1, alu_s0, alu_cin}), 32'h0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check($sformatf("v%0d_valid_drop", idx), 32'(rsp_valid), 32'h0);
    check($sformatf("v%0d_ready_back", idx), 32'(req_ready), 32'h1);
  endtask

  initial begin
    int lat;
    int guard;
    int base_acc;
    int base_hs;
    int h1;
    logic [15:0] d1;

    vecs[0] = '{a: 16'h1234, b: 16'h0FCD, sel: 2'b00, cin: 1'b0, d: 16'h2201, cout: 1'b0, zero: 1'b0};
    vecs[1] = '{a: 16'h0005, b: 16'h0003, sel: 2'b01, cin: 1'b1, d: 16'h0002, cout: 1'b1, zero: 1'b0};
    vecs[2] = '{a: 16'h0005, b: 16'h0003, sel: 2'b01, cin: 1'b0, d: 16'h0001, cout: 1'b1, zero: 1'b0};
    vecs[3] = '{a: 16'hFFFF, b: 16'h0000, sel: 2'b10, cin: 1'b1, d: 16'h0000, cout: 1'b1, zero: 1'b1};
    vecs[4] = '{a: 16'h0000, b: 16'h0000, sel: 2'b11, cin: 1'b0, d: 16'hFFFF, cout: 1'b0, zero: 1'b0};
    vecs[5] = '{a: 16'h8000, b: 16'h8000, sel: 2'b01, cin: 1'b1, d: 16'h0000, cout: 1'b1, zero: 1'b1};
    vecs[6] = '{a: 16'hA5A5, b: 16'h5A5A, sel: 2'b00, cin: 1'b1, d: 16'h0000, cout: 1'b1, zero: 1'b1};
    vecs[7] = '{a: 16'h00F0, b: 16'hFFFF, sel: 2'b10, cin: 1'b0, d: 16'h00F0, cout: 1'b0, zero: 1'b0};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_a     = 16'h0;
    req_b     = 16'h0;
    req_sel   = 2'b00;
    req_cin   = 1'b0;
    rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_zero", 32'(rsp_zero), 32'h1);
    check("rst_rsp_cout", 32'(rsp_cout), 32'h0);
    check("rst_rsp_d", 32'(rsp_d), 32'h0);
    check("rst_alu", 32'({alu_a, alu_b, alu_s1, alu_s0, alu_cin}), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], i);
    end

    // Backpressure: the response holds while a new request is ignored
    base_acc = acc_cnt;
    start_req(vecs[0]);
    wait_rsp(lat);
    check("bp_latency", 32'(lat), 32'd4);
    req_a     = 16'h1111;
    req_b     = 16'h2222;
    req_sel   = 2'b00;
    req_cin   = 1'b1;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("bp_valid_c%0d", i), 32'(rsp_valid), 32'h1);
      check($sformatf("bp_d_c%0d", i), 32'(rsp_d), 32'h2201);
      check($sformatf("bp_cout_c%0d", i), 32'(rsp_cout), 32'h0);
      check($sformatf("bp_ready_c%0d", i), 32'(req_ready), 32'h0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_valid_drop", 32'(rsp_valid), 32'h0);
    repeat (6) @(negedge clk);
    check("bp_no_phantom_rsp", 32'(rsp_valid), 32'h0);
    check("bp_accept_count", 32'(acc_cnt - base_acc), 32'd1);

    // Reset in the middle of EXEC at nibble 2
    start_req(vecs[0]);
    @(negedge clk);
    @(negedge clk);
    check("mid_alu_a_k2", 32'(alu_a), 32'h2);
    check("mid_alu_b_k2", 32'(alu_b), 32'hF);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mid_req_ready", 32'(req_ready), 32'h1);
    check("mid_rsp_valid", 32'(rsp_valid), 32'h0);
    check("mid_alu", 32'({alu_a, alu_b, alu_s1, alu_s0, alu_cin}), 32'h0);
    guard = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) guard++;
    end
    check("mid_no_rsp", 32'(guard), 32'd0);
    run_vec(vecs[1], 10);

    // Back-to-back requests with rsp_ready held high
    base_acc  = acc_cnt;
    base_hs   = hs_cnt;
    rsp_ready = 1'b1;
    req_a     = vecs[0].a;
    req_b     = vecs[0].b;
    req_sel   = vecs[0].sel;
    req_cin   = vecs[0].cin;
    req_valid = 1'b1;
    guard = 0;
    while (acc_cnt != base_acc + 1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("b2b_first_accept", 32'(acc_cnt - base_acc), 32'd1);
    req_a   = vecs[2].a;
    req_b   = vecs[2].b;
    req_sel = vecs[2].sel;
    req_cin = vecs[2].cin;
    guard = 0;
    while (hs_cnt != base_hs + 1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    h1 = hs_cyc;
    d1 = hs_d;
    guard = 0;
    while (acc_cnt != base_acc + 2 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b0;
    check("b2b_second_accept", 32'(acc_cnt - base_acc), 32'd2);
    check("b2b_accept_timing", 32'(acc_cyc - h1), 32'd1);
    guard = 0;
    while (hs_cnt != base_hs + 2 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    rsp_ready = 1'b0;
    check("b2b_first_d", 32'(d1), 32'(vecs[0].d));
    check("b2b_second_d", 32'(hs_d), 32'(vecs[2].d));
    check("b2b_second_count", 32'(hs_cnt - base_hs), 32'd2);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
